grid_ram_scheduler: RTL
=======================

Name: grid_ram_scheduler

Overview:
- Owns the single-port snake-grid cell RAM: 40x30 cells of 16x16 px covering the 640x480 frame.
- Time-shares the RAM between the VGA pixel pipeline and game logic.
- The VGA side reads on every active pixel tick. It always has priority.
- Game logic gets the remaining clock slots through a valid/ready request port. A built-in clear engine wipes the grid on command.

Parameters:
- GRID_W, 40, cells per row
- GRID_H, 30, cells per column
- CELL_SHIFT, 4, log2 of cell size in px
- DATA_W, 2, cell code width (0 empty, 1 snake, 2 food, 3 wall)
- ADDR_W, 11, RAM address width (covers GRID_W*GRID_H = 1200)

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- p_tick  in  1  25 MHz pixel-tick enable from vga_controller; one clk_100MHz cycle in every 4
- video_on  in  1  active-display flag from vga_controller
- x  in  10  current pixel column
- y  in  10  current pixel row
- cell_code  out  DATA_W  cell code for the current pixel
- cell_valid  out  1  one-cycle pulse when cell_code is updated
- req_valid  in  1  game request valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  cell index, row*GRID_W + col
- req_wdata  in  DATA_W  write data
- req_ready  out  1  request accepted this cycle when req_valid is also high
- rsp_valid  out  1  read data valid
- rsp_rdata  out  DATA_W  read data
- clear_start  in  1  pulse: start a grid wipe
- busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse when the wipe completes

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, clear counter 0. Outputs cell_code=0, cell_valid=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, clear_done=0. RAM contents are not reset.
- VGA slot: any cycle with p_tick=1 && video_on=1.
  - Address = (y>>CELL_SHIFT)*GRID_W + (x>>CELL_SHIFT), computed with shift-add as (r<<5)+(r<<3)+c, 11 bits.
  - RAM read in cycle T; RAM read latency is 1 cycle.
  - cell_code registered at T+2, with cell_valid=1 for that one cycle.
- p_tick=1 && video_on=0: no RAM access. cell_code is set to 0 at T+2; cell_valid stays 0.
- req_ready = (state==IDLE) && !vgaslot && !clear_start. It is a combinational function of p_tick and video_on.
- Accepted write: RAM written in the same cycle. No response is generated.
- Accepted read: rsp_valid=1 and rsp_rdata are presented at T+1 for exactly one cycle.
- req_addr >= GRID_W*GRID_H:
  - write is dropped;
  - read returns rsp_rdata=0 with rsp_valid still pulsed at T+1.
- State machine:
  - IDLE -> CLEAR on clear_start. clear_start wins over a simultaneous req_valid.
  - CLEAR: on every non-VGA-slot cycle, write 0 to the counter address, then increment the counter. VGA slots stall the counter. busy=1 and req_ready=0 throughout.
  - CLEAR -> DONE after address 1199 is written.
  - DONE: clear_done=1, busy=0 for one cycle. Counter resets to 0. Then -> IDLE.
- clear_start while in CLEAR or DONE: ignored.
- Wipe duration: 1200 writes. Worst case during active video is 1600 clocks.
- VGA reads during a wipe may return stale or cleared data; this is acceptable.
- reset asserted mid-CLEAR: abort immediately. The RAM is left partially cleared; no clear_done.
- A pending read response is lost on reset.

Optional Feature:
- Macro: VBLANK_WRITES_EN.
- Defined:
  - game writes are accepted only during vertical blanking (y >= 480);
  - req_ready=0 for writes outside vblank, which removes tearing;
  - reads are unaffected;
  - the clear engine is likewise restricted to vblank.
- Undefined: writes are accepted in any non-VGA slot, as described above.

Decomposition:
- Shared package snek_pkg holds:
  - GRID_W, GRID_H, CELL_SHIFT, DATA_W, ADDR_W;
  - cell code constants CELL_EMPTY, CELL_SNAKE, CELL_FOOD, CELL_WALL;
  - scheduler state enum IDLE/CLEAR/DONE.
- One sub-module, grid_ram: single-port synchronous RAM with 1-cycle read, depth GRID_W*GRID_H, no reset, instantiated inside.

Test Plan:
- VGA read path: write code 2 at addr 41 (row 1, col 1). Drive x=20, y=16, video_on=1 with p_tick at T -> cell_code=2 and cell_valid=1 at T+2.
- Priority: hold req_valid=1 (read, addr 41) continuously while p_tick toggles with video_on=1.
  - req_ready=0 on every p_tick cycle; req_ready=1 otherwise.
  - rsp_rdata=2 one cycle after each acceptance.
- Out-of-range: write addr 1200 data 3, then read addr 1200 -> rsp_valid=1 and rsp_rdata=0. A read of addr 1199 is unchanged.
- Clear:
  - fill all 1200 cells with 3, pulse clear_start together with req_valid=1 -> request not accepted; busy=1 next cycle.
  - clear_done pulses once; all reads then return 0.
  - clear_start issued mid-wipe is ignored.
- Reset mid-clear: assert reset (low) at counter around 600 -> busy=0, no clear_done. Cells 0-599 read 0 and cells 600-1199 read 3.
- Blanking: video_on=0 -> no cell_valid, and cell_code=0 two cycles after p_tick. With VBLANK_WRITES_EN, a write at y=100 stalls until y=480.

Source files
------------

// File: rtl/snek_pkg.sv
// rtl/snek_pkg.sv - shared grid geometry, cell codes and scheduler state for the snake grid
package snek_pkg;
    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;
    localparam int DATA_W     = 2;
    localparam int ADDR_W     = 11;
    localparam int CELLS      = GRID_W * GRID_H;

    localparam logic [DATA_W-1:0] CELL_EMPTY = 2'd0;
    localparam logic [DATA_W-1:0] CELL_SNAKE = 2'd1;
    localparam logic [DATA_W-1:0] CELL_FOOD  = 2'd2;
    localparam logic [DATA_W-1:0] CELL_WALL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } sched_state_e;
endpackage

// File: rtl/grid_ram.sv
// rtl/grid_ram.sv - single-port grid cell RAM, 1-cycle registered read, no reset
module grid_ram
    import snek_pkg::*;
(
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [CELLS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/grid_ram_scheduler.sv
// rtl/grid_ram_scheduler.sv - shares the grid RAM between VGA reads, game requests and a clear engine
// Build option VBLANK_WRITES_EN restricts game writes and the clear engine to vertical blanking.
module grid_ram_scheduler
    import snek_pkg::*;
(
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [DATA_W-1:0] cell_code,
    output logic              cell_valid,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done
);
    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              vga_rd_q, vga_blank_q, game_rd_q, oor_q;
    logic              game_rd_d, oor_d;
    logic [DATA_W-1:0] cell_code_q, cell_code_d;
    logic              cell_valid_q;

    logic              vga_slot, in_range, wr_allowed, clr_allowed;
    logic [9:0]        row, col;
    logic [ADDR_W-1:0] vga_addr;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign vga_slot = p_tick && video_on;
    assign row      = y >> CELL_SHIFT;
    assign col      = x >> CELL_SHIFT;
    // row*40 as shift-add keeps the address path free of a multiplier
    assign vga_addr = (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col);
    assign in_range = req_addr < ADDR_W'(CELLS);

`ifdef VBLANK_WRITES_EN
    assign wr_allowed  = y >= 10'd480;
`else
    assign wr_allowed  = 1'b1;
`endif
    assign clr_allowed = !vga_slot && wr_allowed;

    assign req_ready = reset && (state_q == IDLE) && !vga_slot && !clear_start
                       && (!req_we || wr_allowed);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_en    = vga_slot;
        ram_we    = 1'b0;
        ram_addr  = vga_addr;
        ram_wdata = CELL_EMPTY;
        game_rd_d = 1'b0;
        oor_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                end else if (req_valid && req_ready) begin
                    ram_addr  = req_addr;
                    ram_en    = in_range;
                    ram_we    = req_we;
                    ram_wdata = req_wdata;
                    game_rd_d = !req_we;
                    oor_d     = !in_range;
                end
            end
            CLEAR: begin
                if (clr_allowed) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cnt_q;
                    if (cnt_q == ADDR_W'(CELLS - 1)) state_d = DONE;
                    else                             cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM data lands one cycle after a VGA read, so the cell register updates two cycles after the tick
    always_comb begin
        cell_code_d = cell_code_q;
        if (vga_rd_q)         cell_code_d = ram_rdata;
        else if (vga_blank_q) cell_code_d = CELL_EMPTY;
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vga_rd_q     <= 1'b0;
            vga_blank_q  <= 1'b0;
            game_rd_q    <= 1'b0;
            oor_q        <= 1'b0;
            cell_code_q  <= CELL_EMPTY;
            cell_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vga_rd_q     <= vga_slot;
            vga_blank_q  <= p_tick && !video_on;
            game_rd_q    <= game_rd_d;
            oor_q        <= oor_d;
            cell_code_q  <= cell_code_d;
            cell_valid_q <= vga_rd_q;
        end
    end

    grid_ram u_grid_ram (
        .clk_i   (clk_100MHz),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign cell_code  = cell_code_q;
    assign cell_valid = cell_valid_q;
    assign rsp_valid  = game_rd_q;
    assign rsp_rdata  = (game_rd_q && !oor_q) ? ram_rdata : CELL_EMPTY;
    assign busy       = (state_q == CLEAR);
    assign clear_done = (state_q == DONE);
endmodule
